// File: rtl/pal_pkg.sv
// Shared FSM encoding, CRC polynomial and CRC byte-update helper for the
// PAL configuration loader.
package pal_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } pal_state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  // MSB-first CRC-8 over one byte, no reflection, no final XOR.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) begin
        c = {c[6:0], 1'b0} ^ CRC8_POLY;
      end else begin
        c = {c[6:0], 1'b0};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/pal_crc8.sv
// Combinational next-CRC for one accepted configuration byte.
module pal_crc8
  import pal_pkg::*;
(
  input  logic [7:0] crc,
  input  logic [7:0] data,
  output logic [7:0] crc_next
);

  // Next CRC from the running value and the incoming byte
  always_comb begin
    crc_next = crc8_update(crc, data);
  end

endmodule

// File: rtl/pal_cfg_loader.sv
// Byte-to-serial PAL configuration loader: streams CFG_BITS bits LSB first,
// then checks a trailing CRC-8 byte before enabling the fabric.
module pal_cfg_loader
  import pal_pkg::*;
#(
  parameter int CFG_BITS = 600
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       start,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       cfg,
  output logic       cfg_valid,
  output logic       pal_en,
  output logic       busy,
  output logic       err
);

  localparam int NUM_BYTES = (CFG_BITS + 7) / 8;
  localparam int LAST_BITS = CFG_BITS - 8 * (NUM_BYTES - 1);
  localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(NUM_BYTES - 1);
  localparam logic [3:0]       LAST_NBITS = 4'(LAST_BITS);

  pal_state_e       state_r;
  logic [7:0]       shreg_r;
  logic [7:0]       crc_r;
  logic [CNT_W-1:0] byte_cnt_r;
  logic [3:0]       bit_cnt_r;
  logic             byte_ready_r;
  logic             cfg_r;
  logic             cfg_valid_r;
  logic             pal_en_r;
  logic             busy_r;
  logic             err_r;

  logic [7:0]       crc_next_s;
  logic             accept_s;
  logic             last_byte_s;
  logic [3:0]       byte_bits_s;

  pal_crc8 u_crc (
    .crc      (crc_r),
    .data     (byte_data),
    .crc_next (crc_next_s)
  );

  assign accept_s    = byte_valid & byte_ready_r;
  assign last_byte_s = (byte_cnt_r == LAST_IDX);
  // The final byte only carries LAST_BITS fabric bits; the rest are CRC-only padding.
  assign byte_bits_s = last_byte_s ? LAST_NBITS : 4'd8;

  // Loader FSM with all outputs registered alongside the state
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_r      <= IDLE;
      shreg_r      <= 8'h00;
      crc_r        <= 8'h00;
      byte_cnt_r   <= '0;
      bit_cnt_r    <= 4'd0;
      byte_ready_r <= 1'b0;
      cfg_r        <= 1'b0;
      cfg_valid_r  <= 1'b0;
      pal_en_r     <= 1'b0;
      busy_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE, ERR: begin
          if (start) begin
            pal_en_r     <= 1'b0;
            err_r        <= 1'b0;
            crc_r        <= 8'h00;
            byte_cnt_r   <= '0;
            bit_cnt_r    <= 4'd0;
            busy_r       <= 1'b1;
            byte_ready_r <= 1'b1;
            state_r      <= LOAD;
          end
        end
        LOAD: begin
          if (accept_s) begin
            // Bit 0 goes out immediately so it is visible the cycle after acceptance.
            shreg_r      <= byte_data;
            crc_r        <= crc_next_s;
            cfg_r        <= byte_data[0];
            cfg_valid_r  <= 1'b1;
            bit_cnt_r    <= 4'd1;
            byte_ready_r <= 1'b0;
            state_r      <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_cnt_r >= byte_bits_s) begin
            cfg_r        <= 1'b0;
            cfg_valid_r  <= 1'b0;
            bit_cnt_r    <= 4'd0;
            byte_ready_r <= 1'b1;
            if (last_byte_s) begin
              state_r <= CHECK;
            end else begin
              byte_cnt_r <= byte_cnt_r + CNT_W'(1);
              state_r    <= LOAD;
            end
          end else begin
            cfg_r     <= shreg_r[bit_cnt_r[2:0]];
            bit_cnt_r <= bit_cnt_r + 4'd1;
          end
        end
        CHECK: begin
          if (accept_s) begin
            byte_ready_r <= 1'b0;
            busy_r       <= 1'b0;
            if (byte_data == crc_r) begin
              pal_en_r <= 1'b1;
              state_r  <= DONE;
            end else begin
              err_r   <= 1'b1;
              state_r <= ERR;
            end
          end
        end
        default: begin
          byte_ready_r <= 1'b0;
          cfg_r        <= 1'b0;
          cfg_valid_r  <= 1'b0;
          pal_en_r     <= 1'b0;
          busy_r       <= 1'b0;
          err_r        <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  // cfg_valid is the PAL shift enable, cfg its serial data, pal_en its enable.
  assign byte_ready = byte_ready_r;
  assign cfg        = cfg_r;
  assign cfg_valid  = cfg_valid_r;
  assign pal_en     = pal_en_r;
  assign busy       = busy_r;
  assign err        = err_r;

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Bench for pal_cfg_loader: table-driven loads on a 12-bit build with a cfg
// bit scoreboard, reset/abort sequence, and a 16-bit all-zero load.
module tb_pal_cfg_loader;

  localparam int LAST_A = 4;

  logic       clk = 1'b0;
  logic       res_n;
  logic       start_a, byte_valid_a;
  logic [7:0] byte_data_a;
  logic       byte_ready_a, cfg_a, cfg_valid_a, pal_en_a, busy_a, err_a;
  logic       start_b, byte_valid_b;
  logic [7:0] byte_data_b;
  logic       byte_ready_b, cfg_b, cfg_valid_b, pal_en_b, busy_b, err_b;

  always #5 clk = ~clk;

  pal_cfg_loader #(.CFG_BITS(12)) dut_a (
    .clk(clk), .res_n(res_n), .start(start_a), .byte_data(byte_data_a),
    .byte_valid(byte_valid_a), .byte_ready(byte_ready_a), .cfg(cfg_a),
    .cfg_valid(cfg_valid_a), .pal_en(pal_en_a), .busy(busy_a), .err(err_a)
  );

  pal_cfg_loader #(.CFG_BITS(16)) dut_b (
    .clk(clk), .res_n(res_n), .start(start_b), .byte_data(byte_data_b),
    .byte_valid(byte_valid_b), .byte_ready(byte_ready_b), .cfg(cfg_b),
    .cfg_valid(cfg_valid_b), .pal_en(pal_en_b), .busy(busy_b), .err(err_b)
  );

  typedef struct {
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] crcb;
    bit         ok;
    bit         hold;
    bit         mid_start;
  } vec_t;

  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];
  int   vcount_a = 0;
  int   vcount_b = 0;
  int   acc_a = 0;
  logic ready_prev_a = 1'b0;
  bit   hold_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Independent reference: bitwise long division of the two-byte message.
  function automatic logic [7:0] model_crc(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] msg;
    logic [7:0]  r;
    logic        fb;
    msg = {a, b};
    r   = 8'h00;
    for (int i = 15; i >= 0; i--) begin
      fb = r[7] ^ msg[i];
      r  = {r[6:0], 1'b0};
      if (fb) r = r ^ 8'h07;
    end
    return r;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Monitor: scoreboard for cfg bits, invariants, acceptance counting
  always @(negedge clk) begin
    if (cfg_valid_a) begin
      vcount_a++;
      check("cfg_valid_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("cfg_bit", cfg_a, exp_q.pop_front());
    end else begin
      check("cfg_zero_when_invalid", cfg_a, 0);
    end
    check("ready_not_while_shifting", byte_ready_a & cfg_valid_a, 0);
    check("ready_only_when_busy", byte_ready_a & ~busy_a, 0);
    if (byte_valid_a && ready_prev_a) acc_a++;
    ready_prev_a = byte_ready_a;
    if (cfg_valid_b) vcount_b++;
    check("b_cfg_zero", cfg_b, 0);
  end

  task automatic send_byte(input logic [7:0] b, input int nbits);
    int waited = 0;
    byte_data_a  = b;
    byte_valid_a = 1'b1;
    while (!byte_ready_a && waited < 40) begin
      step();
      waited++;
    end
    check("byte_ready_within_budget", byte_ready_a, 1);
    if (!byte_ready_a) begin
      byte_valid_a = 1'b0;
      return;
    end
    @(posedge clk);
    for (int i = 0; i < nbits; i++) exp_q.push_back(b[i]);
    step();
    if (!hold_valid) byte_valid_a = 1'b0;
    if (nbits > 0) check("first_bit_latency", cfg_valid_a, 1);
  endtask

  task automatic run_load(input vec_t v);
    int v0, a0;
    hold_valid = v.hold;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check("start_enters_load", {busy_a, byte_ready_a, pal_en_a, err_a}, 4'b1100);
    v0 = vcount_a;
    a0 = acc_a;
    send_byte(v.d0, 8);
    if (v.mid_start) begin
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      check("start_ignored_busy", busy_a, 1);
    end
    send_byte(v.d1, LAST_A);
    send_byte(v.crcb, 0);
    check("pal_en", pal_en_a, v.ok);
    check("err", err_a, !v.ok);
    check("busy_after_check", busy_a, 0);
    check("cfg_valid_count", vcount_a - v0, 12);
    check("scoreboard_drained", exp_q.size(), 0);
    repeat (3) step();
    check("result_held", {pal_en_a, err_a}, {v.ok, !v.ok});
    check("bytes_accepted", acc_a - a0, 3);
    byte_valid_a = 1'b0;
    hold_valid   = 1'b0;
    step();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int v0, waited;
    vecs[0] = '{8'h01, 8'h00, 8'h15, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 8'h00, 8'h14, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{8'h01, 8'h00, 8'h15, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h01, 8'h00, 8'h15, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{8'hA5, 8'hF3, model_crc(8'hA5, 8'hF3), 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'hA5, 8'h03, model_crc(8'hA5, 8'hF3), 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'hFF, 8'hFF, model_crc(8'hFF, 8'hFF), 1'b1, 1'b1, 1'b1};
    vecs[7] = '{8'h3C, 8'h0A, model_crc(8'h3C, 8'h0A) ^ 8'h01, 1'b0, 1'b0, 1'b0};

    start_a = 1'b0; byte_valid_a = 1'b0; byte_data_a = 8'h00;
    start_b = 1'b0; byte_valid_b = 1'b0; byte_data_b = 8'h00;
    res_n = 1'b1;
    #1 res_n = 1'b0;
    repeat (3) step();
    check("reset_outputs_a", {byte_ready_a, cfg_a, cfg_valid_a, pal_en_a, busy_a, err_a}, 6'b0);
    check("reset_outputs_b", {byte_ready_b, cfg_b, cfg_valid_b, pal_en_b, busy_b, err_b}, 6'b0);
    res_n = 1'b1;
    repeat (2) step();
    check("idle_after_reset", {busy_a, byte_ready_a, pal_en_a}, 3'b000);

    // 16-bit build: two zero bytes and a zero CRC, valid held high throughout
    byte_data_b  = 8'h00;
    byte_valid_b = 1'b1;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    v0 = vcount_b;
    waited = 0;
    while (!pal_en_b && !err_b && waited < 200) begin
      step();
      waited++;
    end
    check("b_done", {pal_en_b, err_b, busy_b}, 3'b100);
    check("b_cfg_valid_count", vcount_b - v0, 16);
    byte_valid_b = 1'b0;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    check("b_pal_en_drops", {pal_en_b, busy_b}, 2'b01);

    for (int i = 0; i < 8; i++) run_load(vecs[i]);

    // Reset mid-load after the 5th cfg_valid
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    send_byte(8'hB6, 8);
    repeat (4) step();
    check("fifth_bit_present", cfg_valid_a, 1);
    res_n = 1'b0;
    #1;
    check("reset_aborts_load", {byte_ready_a, cfg_a, cfg_valid_a, pal_en_a, busy_a, err_a}, 6'b0);
    exp_q.delete();
    v0 = vcount_a;
    repeat (2) step();
    res_n = 1'b1;
    repeat (10) step();
    check("no_cfg_after_reset", vcount_a - v0, 0);
    check("idle_until_start", {busy_a, byte_ready_a}, 2'b00);
    run_load(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
